// File: rtl/muldiv_unit.sv
// Iterative 32-cycle multiply/divide unit: shift-add multiply, restoring divide.
// Signed ops run on magnitudes and fix signs in the final RUN cycle.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero,
  output logic [1:0]       stateDbg
);

  // Handshake: start is sampled on each rising edge and accepted only in IDLE or
  // FINISH (busy=0); done pulses for the single FINISH cycle with hi/lo valid.

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] ITERS = CW'(WIDTH);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } stateT;

  stateT              state;
  logic [CW-1:0]      count;
  logic [1:0]         opReg;
  logic [WIDTH-1:0]   aReg;
  logic               aNegReg;
  logic               bNegReg;
  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   divisor;
  logic [2*WIDTH-1:0] prodAcc;
  logic [WIDTH-1:0]   remAcc;
  logic [WIDTH-1:0]   quoAcc;

  logic               aNeg;
  logic               bNeg;
  logic [WIDTH-1:0]   aMag;
  logic [WIDTH-1:0]   bMag;
  logic [WIDTH:0]     mulSum;
  logic [WIDTH:0]     divShift;
  logic [WIDTH:0]     divDiff;
  logic               divFits;
  logic               resNeg;
  logic               remNeg;
  logic [2*WIDTH-1:0] prodFinal;
  logic [WIDTH-1:0]   quoFinal;
  logic [WIDTH-1:0]   remFinal;

  // Unsigned negation of the most negative value yields 2^(WIDTH-1), as required.
  always_comb begin
    aNeg = ~op[0] & a[WIDTH-1];
    bNeg = ~op[0] & b[WIDTH-1];
    aMag = aNeg ? -a : a;
    bMag = bNeg ? -b : b;
  end

  always_comb begin
    mulSum   = {1'b0, prodAcc[2*WIDTH-1:WIDTH]} + (prodAcc[0] ? {1'b0, mcand} : '0);
    divShift = {remAcc, quoAcc[WIDTH-1]};
    divFits  = (divShift >= {1'b0, divisor});
    divDiff  = divShift - {1'b0, divisor};
  end

  always_comb begin
    resNeg    = ~opReg[0] & (aNegReg ^ bNegReg);
    remNeg    = ~opReg[0] & aNegReg;
    prodFinal = resNeg ? -prodAcc : prodAcc;
    quoFinal  = resNeg ? -quoAcc : quoAcc;
    remFinal  = remNeg ? -remAcc : remAcc;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      count       <= '0;
      opReg       <= '0;
      aReg        <= '0;
      aNegReg     <= 1'b0;
      bNegReg     <= 1'b0;
      mcand       <= '0;
      divisor     <= '0;
      prodAcc     <= '0;
      remAcc      <= '0;
      quoAcc      <= '0;
      hi          <= '0;
      lo          <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE, FINISH: begin
          if (start) begin
            state   <= RUN;
            count   <= ITERS;
            opReg   <= op;
            aReg    <= a;
            aNegReg <= aNeg;
            bNegReg <= bNeg;
            mcand   <= aMag;
            divisor <= bMag;
            prodAcc <= {{WIDTH{1'b0}}, bMag};
            remAcc  <= '0;
            quoAcc  <= aMag;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          if (count != '0) begin
            count <= count - 1'b1;
            if (opReg[1]) begin
              remAcc <= divFits ? divDiff[WIDTH-1:0] : divShift[WIDTH-1:0];
              quoAcc <= {quoAcc[WIDTH-2:0], divFits};
            end else begin
              prodAcc <= {mulSum, prodAcc[WIDTH-1:1]};
            end
          end else begin
            // Counter exhausted: publish sign-corrected results and enter FINISH.
            state <= FINISH;
            if (!opReg[1]) begin
              {hi, lo}    <= prodFinal;
              div_by_zero <= 1'b0;
            end else if (divisor == '0) begin
              hi          <= aReg;
              lo          <= '1;
              div_by_zero <= 1'b1;
            end else begin
              hi          <= remFinal;
              lo          <= quoFinal;
              div_by_zero <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy     = (state == RUN);
  assign done     = (state == FINISH);
  assign stateDbg = state;

endmodule

// File: tb/tb_muldiv_unit.sv
// Randomized and directed bench for muldiv_unit against a plain-arithmetic model.
module tb_muldiv_unit;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;
  logic         div_by_zero;
  logic [1:0]   stateDbg;

  int checks = 0;
  int errors = 0;
  logic running = 1'b0;
  logic [2*W:0] exp_q[$];

  always #5 clk = ~clk;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .hi(hi), .lo(lo), .div_by_zero(div_by_zero),
    .stateDbg(stateDbg)
  );

  task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [2*W:0] mk(input logic dbz, input logic [W-1:0] h, input logic [W-1:0] l);
    return {dbz, h, l};
  endfunction

  // Reference: 64-bit integer arithmetic; signed / and % truncate toward zero.
  function automatic logic [2*W:0] model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    longint sx, sy, q, r;
    logic [63:0] p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    case (o)
      2'd0: begin p = sx * sy; return {1'b0, p}; end
      2'd1: begin p = {32'd0, x} * {32'd0, y}; return {1'b0, p}; end
      default: begin
        if (y == '0) return mk(1'b1, x, '1);
        if (o == 2'd2) begin
          q = sx / sy; r = sx % sy;
          return mk(1'b0, r[W-1:0], q[W-1:0]);
        end
        return mk(1'b0, x % y, x / y);
      end
    endcase
  endfunction

  task automatic runOp(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic [2*W:0] expVec, input string tag);
    logic [W-1:0] prevHi, prevLo;
    logic [2*W:0] e;
    int cyc;
    prevHi = hi;
    prevLo = lo;
    exp_q.push_back(expVec);
    @(negedge clk); start = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1; start = 1'b0;
    cyc = 0;
    while (!done && cyc < 50) begin
      @(posedge clk); #1; cyc++;
      if (cyc == 1) checkVal({tag, "_busy"}, 64'(busy), 64'd1);
      if (cyc == 16) checkVal({tag, "_hold"}, {hi, lo}, {prevHi, prevLo});
    end
    checkVal({tag, "_latency"}, 64'(cyc), 64'd33);
    checkVal({tag, "_busy_fin"}, 64'(busy), 64'd0);
    e = exp_q.pop_front();
    checkVal({tag, "_hi"}, 64'(hi), 64'(e[2*W-1:W]));
    checkVal({tag, "_lo"}, 64'(lo), 64'(e[W-1:0]));
    checkVal({tag, "_dbz"}, 64'(div_by_zero), 64'(e[2*W]));
    @(posedge clk); #1;
    checkVal({tag, "_pulse"}, 64'(done), 64'd0);
  endtask

  function automatic logic [W-1:0] pickOperand(input bit smallOk);
    case ($urandom_range(0, 7))
      0: return '0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'd1;
      4: return smallOk ? W'($urandom_range(1, 15)) : W'($urandom);
      default: return W'($urandom);
    endcase
  endfunction

  always @(negedge clk) if (running) checkVal("busy_done_excl", 64'(busy & done), 64'd0);

  initial begin
    int cyc, cyc2;
    logic sawDone;
    logic [2*W:0] e;
    logic [1:0] ro;
    logic [W-1:0] ra, rb;

    reset = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    running = 1'b1;
    checkVal("rst_busy", 64'(busy), 64'd0);
    checkVal("rst_done", 64'(done), 64'd0);
    checkVal("rst_hilo", {hi, lo}, 64'd0);
    checkVal("rst_dbz", 64'(div_by_zero), 64'd0);
    checkVal("rst_state", 64'(stateDbg), 64'd0);
    reset = 1'b0;

    runOp(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, mk(1'b0, 32'hFFFF_FFFE, 32'h0000_0001), "multu_max");
    runOp(2'd0, 32'hFFFF_FFF9, 32'd3, mk(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFEB), "mult_neg");
    runOp(2'd2, 32'hFFFF_FFF9, 32'd2, mk(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFD), "div_neg");
    runOp(2'd3, 32'd100, 32'd0, mk(1'b1, 32'd100, 32'hFFFF_FFFF), "divu_zero");
    runOp(2'd3, 32'd100, 32'd7, mk(1'b0, 32'd2, 32'd14), "divu_7");
    runOp(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, mk(1'b0, 32'd0, 32'h8000_0000), "div_wrap");
    runOp(2'd2, 32'hFFFF_FFFB, 32'd0, mk(1'b1, 32'hFFFF_FFFB, 32'hFFFF_FFFF), "div_zero_s");
    runOp(2'd0, 32'h8000_0000, 32'h8000_0000, mk(1'b0, 32'h4000_0000, 32'd0), "mult_minmin");
    runOp(2'd2, 32'd7, 32'hFFFF_FFFE, mk(1'b0, 32'd1, 32'hFFFF_FFFD), "div_pos_neg");

    // Ignored start mid-run, then reset aborting a second operation.
    @(negedge clk); start = 1'b1; op = 2'd1; a = 32'd5; b = 32'd6;
    @(posedge clk); #1; start = 1'b0;
    cyc = 0;
    while (!done && cyc < 50) begin
      @(posedge clk); #1; cyc++;
      if (cyc == 10) begin start = 1'b1; op = 2'd0; a = 32'd9; b = 32'd9; end
      if (cyc == 11) start = 1'b0;
    end
    checkVal("ign_latency", 64'(cyc), 64'd33);
    checkVal("ign_result", {hi, lo}, 64'd30);
    @(negedge clk); start = 1'b1; op = 2'd1; a = 32'd7; b = 32'd8;
    @(posedge clk); #1; start = 1'b0;
    repeat (19) @(posedge clk);
    #1; reset = 1'b1;
    @(posedge clk); #1; reset = 1'b0;
    checkVal("abort_busy", 64'(busy), 64'd0);
    checkVal("abort_done", 64'(done), 64'd0);
    checkVal("abort_hilo", {hi, lo}, 64'd0);
    sawDone = 1'b0;
    repeat (20) begin
      @(posedge clk); #1;
      if (done) sawDone = 1'b1;
    end
    checkVal("abort_no_done", 64'(sawDone), 64'd0);

    // Back-to-back: start held high through FINISH.
    @(negedge clk); start = 1'b1; op = 2'd3; a = 32'd1000; b = 32'd7;
    exp_q.push_back(model(2'd3, 32'd1000, 32'd7));
    @(posedge clk); #1;
    cyc = 0;
    while (!done && cyc < 50) begin @(posedge clk); #1; cyc++; end
    checkVal("b2b_lat1", 64'(cyc), 64'd33);
    e = exp_q.pop_front();
    checkVal("b2b_res1", {hi, lo}, e[2*W-1:0]);
    op = 2'd2; a = 32'hFFFF_FF9C; b = 32'd9;
    exp_q.push_back(mk(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFF5));
    @(posedge clk); #1; start = 1'b0;
    checkVal("b2b_busy", 64'(busy), 64'd1);
    cyc2 = 1;
    while (!done && cyc2 < 60) begin @(posedge clk); #1; cyc2++; end
    checkVal("b2b_gap", 64'(cyc2), 64'd34);
    e = exp_q.pop_front();
    checkVal("b2b_res2", {hi, lo}, e[2*W-1:0]);
    checkVal("b2b_dbz2", 64'(div_by_zero), 64'(e[2*W]));
    @(posedge clk); #1;

    for (int i = 0; i < 60; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = pickOperand(1'b0);
      rb = pickOperand(1'b1);
      runOp(ro, ra, rb, model(ro, ra, rb), $sformatf("rnd%0d_op%0d", i, ro));
    end

    running = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Iterative multiply/divide stage. Its hi/lo outputs feed the ALU result mux ahead of the ALUOut register.

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, operand and result width in bits; all values below assume 32.
REQ-002 The block SHALL have port clk, input, 1 bit: clock; all state updates on the rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: reset, synchronous, active-high.
REQ-004 The block SHALL have port start, input, 1 bit: request a new operation.
REQ-005 The block SHALL have port op, input, 2 bits: 00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU.
REQ-006 The block SHALL have ports a and b, input, 32 bits each: a = multiplicand/dividend, b = multiplier/divisor.
REQ-007 The block SHALL have port busy, output, 1 bit: an operation is in progress.
REQ-008 The block SHALL have port done, output, 1 bit: one-cycle pulse, results valid.
REQ-009 The block SHALL have ports hi and lo, output, 32 bits each: product upper/lower half, or remainder/quotient.
REQ-010 The block SHALL have port div_by_zero, output, 1 bit: the last division had b == 0.

Function
REQ-011 The block SHALL implement FSM states IDLE, RUN and FINISH.
REQ-012 In IDLE or FINISH, start=1 SHALL latch a, b and op, load an iteration counter with 32, and enter RUN on the next edge.
REQ-013 start while busy=1 SHALL be ignored; latched operands and progress SHALL be unaffected.
REQ-014 In RUN, the block SHALL perform one iteration per cycle and decrement the counter.
REQ-015 Multiply iteration: shift-add on a 64-bit accumulator, one multiplier bit per cycle.
REQ-016 Divide iteration: restoring division, one quotient bit per cycle, with a 33-bit remainder subtractor.
REQ-017 When the counter reaches 0, the FSM SHALL go RUN -> FINISH and update hi/lo on that same edge.
REQ-018 done SHALL be 1 for exactly the one cycle the FSM is in FINISH; FINISH SHALL return to IDLE unless start=1.
REQ-019 busy SHALL be 1 exactly while in RUN; busy and done SHALL never both be 1.
REQ-020 Latency: start sampled at edge N -> done=1 in the cycle after edge N+33; hi/lo valid in that same cycle.
REQ-021 hi, lo and div_by_zero SHALL hold their values until the next completion or reset; they SHALL NOT change during RUN.
REQ-022 Signed ops SHALL compute on operand magnitudes.
REQ-023 For signed ops, the product and the quotient SHALL be negated when the operand signs differ.
REQ-024 For signed ops, the remainder SHALL take the sign of the dividend.
REQ-025 MULT/MULTU SHALL give {hi,lo} = full 64-bit product; no truncation, no overflow flag.
REQ-026 DIV/DIVU SHALL give lo = quotient and hi = remainder, with a == b*lo + hi.
REQ-027 Division with b == 0 SHALL still take the full 33 cycles and return lo = 32'hFFFFFFFF, hi = a, div_by_zero = 1.
REQ-028 div_by_zero SHALL be 0 for every completed multiply and for every division with b != 0.
REQ-029 DIV of 32'h80000000 by 32'hFFFFFFFF SHALL return lo = 32'h80000000, hi = 0 (two's-complement wrap), div_by_zero = 0.
REQ-030 Negating 32'h80000000 for its magnitude SHALL treat it as unsigned 2^31 (33-bit internal magnitude or equivalent).
REQ-031 start asserted in the FINISH cycle SHALL be accepted: done=1 in that cycle, busy=1 in the next.

Reset
REQ-032 reset=1 at a clock edge SHALL force state IDLE and clear the counter.
REQ-033 The same reset edge SHALL drive busy=0, done=0, hi=0, lo=0, div_by_zero=0.
REQ-034 Reset SHALL take priority over start.
REQ-035 Reset during RUN SHALL abort the operation: no done pulse, no partial result visible.

Verification
REQ-036 MULTU a=32'hFFFFFFFF, b=32'hFFFFFFFF -> done at start+33; hi=32'hFFFFFFFE, lo=32'h00000001.
REQ-037 MULT a=-7 (32'hFFFFFFF9), b=3 -> hi=32'hFFFFFFFF, lo=32'hFFFFFFEB.
REQ-038 DIV a=-7, b=2 -> lo=32'hFFFFFFFD (-3), hi=32'hFFFFFFFF (-1), div_by_zero=0.
REQ-039 DIVU a=100, b=0 -> lo=32'hFFFFFFFF, hi=100, div_by_zero=1; then DIVU 100/7 -> lo=14, hi=2, div_by_zero=0.
REQ-040 MULTU 5*6, with start pulsed again at cycle 10, then reset at cycle 20 of a second op -> second start ignored; reset aborts, busy=0, hi=lo=0, no done pulse.
REQ-041 Back-to-back: start held high across FINISH -> two done pulses exactly 34 cycles apart; the second result is correct for operands latched at the FINISH cycle.
